// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks (chainer / unchainer).
//   unchain_state_t : state encoding of the output unchainer FSM
//   DAT_WID         : default bits per lane on the narrow streams
package cnn_pkg;

  typedef enum logic [1:0] {UNCH_IDLE, UNCH_SEND} unchain_state_t;

  localparam int DAT_WID = 16;

endpackage

// File: rtl/lane_counter.sv
// Lane index counter shared by the chaining / unchaining blocks.
// Counts 0..MAX, wrapping back to 0 on an increment at MAX.
// Ports:
//   clk    in   rising-edge clock
//   i_srst in   synchronous reset, active-high (count -> 0)
//   i_inc  in   advance the count (wraps at MAX)
//   i_clr  in   force count to 0; takes priority over i_inc
//   o_cnt  out  current lane index (WID bits)
//   o_last out  high while o_cnt == MAX
module lane_counter #(
  parameter int WID = 2,
  parameter int MAX = 3
) (
  input  logic           clk,
  input  logic           i_srst,
  input  logic           i_inc,
  input  logic           i_clr,
  output logic [WID-1:0] o_cnt,
  output logic           o_last
);

  localparam logic [WID-1:0] MAX_V = WID'(MAX);

  logic [WID-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_srst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      // Wrap explicitly so codes above MAX are never reached.
      r_cnt <= (r_cnt == MAX_V) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == MAX_V);

endmodule

// File: rtl/output_unchaining.sv
// Output unchainer: accepts one wide word of OC0 lanes over a vld/rdy
// handshake and emits the lanes, lane 0 first, one per handshake on a
// DAT_WID-bit vld/rdy stream. done pulses for one cycle after the last lane.
// Build option: `define UNCHAIN_BACK_TO_BACK_EN lets the next wide word be
// accepted on the same cycle as the last-lane handshake (no bubble cycle).
// Ports:
//   clk                 in   rising-edge clock
//   rst_n               in   synchronous reset, active-high (1 = reset)
//   en_output           in   enable; 0 blocks both handshakes, state held
//   output_dat_chained  in   wide word, lane k = bits [DAT_WID*k +: DAT_WID]
//   chained_vld         in   wide word valid
//   chained_rdy         out  block can accept a wide word
//   output_dat          out  current lane
//   output_vld          out  output_dat valid
//   output_rdy          in   downstream accepts output_dat
//   done                out  one-cycle pulse after the last lane is sent
module output_unchaining #(
  parameter int OC0         = 4,
  parameter int COUNTER_WID = 2,
  parameter int DAT_WID     = cnn_pkg::DAT_WID
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_output,
  input  logic [DAT_WID*OC0-1:0] output_dat_chained,
  input  logic                   chained_vld,
  output logic                   chained_rdy,
  output logic [DAT_WID-1:0]     output_dat,
  output logic                   output_vld,
  input  logic                   output_rdy,
  output logic                   done
);
  import cnn_pkg::*;

  unchain_state_t         r_state;
  unchain_state_t         w_state_next;
  logic [DAT_WID*OC0-1:0] r_buf;
  logic                   r_done;
  logic [COUNTER_WID-1:0] w_idx;
  logic                   w_last;
  logic                   w_in_fire;
  logic                   w_out_fire;
  logic [DAT_WID-1:0]     w_lane [OC0];

  genvar gi;
  generate
    for (gi = 0; gi < OC0; gi++) begin : g_lane
      assign w_lane[gi] = r_buf[DAT_WID*gi +: DAT_WID];
    end
  endgenerate

  lane_counter #(
    .WID (COUNTER_WID),
    .MAX (OC0 - 1)
  ) u_lane_counter (
    .clk    (clk),
    .i_srst (rst_n),
    .i_inc  (w_out_fire),
    .i_clr  (w_in_fire),
    .o_cnt  (w_idx),
    .o_last (w_last)
  );

  // Handshake outputs are forced low while reset is asserted so nothing
  // transfers on the reset edge (a word in flight is simply dropped).
  always_comb begin
    chained_rdy  = 1'b0;
    output_vld   = 1'b0;
    output_dat   = '0;
    w_state_next = r_state;
    if (!rst_n) begin
      case (r_state)
        UNCH_IDLE: chained_rdy = en_output;
        UNCH_SEND: begin
          output_vld = en_output;
          output_dat = w_lane[w_idx];
`ifdef UNCHAIN_BACK_TO_BACK_EN
          // Refill on the last-lane handshake so the next word follows
          // without a bubble.
          if (en_output && w_last) chained_rdy = output_rdy;
`endif
        end
        default: ;
      endcase
    end
    w_in_fire  = chained_vld && chained_rdy;
    w_out_fire = output_vld && output_rdy;
    case (r_state)
      UNCH_IDLE: if (w_in_fire) w_state_next = UNCH_SEND;
      UNCH_SEND: if (w_out_fire && w_last) w_state_next = w_in_fire ? UNCH_SEND : UNCH_IDLE;
      default:   w_state_next = UNCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= UNCH_IDLE;
      r_buf   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_in_fire) r_buf <= output_dat_chained;
      r_done <= w_out_fire && w_last;
    end
  end

  assign done = r_done;

endmodule

// File: tb/tb_output_unchaining.sv
module tb_output_unchaining;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_output;
  logic [63:0]  output_dat_chained;
  logic         chained_vld;
  logic         chained_rdy;
  logic [15:0]  output_dat;
  logic         output_vld;
  logic         output_rdy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  output_unchaining dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .en_output          (en_output),
    .output_dat_chained (output_dat_chained),
    .chained_vld        (chained_vld),
    .chained_rdy        (chained_rdy),
    .output_dat         (output_dat),
    .output_vld         (output_vld),
    .output_rdy         (output_rdy),
    .done               (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] W3 = 64'h00DD_00CC_00BB_00AA;

  initial begin
    logic [15:0] exp5 [4];
    logic [15:0] exp6 [8];
    logic [63:0] words [2];
    int e, n, dn, first, last, qi, span;
    logic in_f, out_f;

    exp5 = '{16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD};
    exp6 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004,
             16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD};
    words = '{W1, W3};

    rst_n = 1'b1; en_output = 1'b1; output_dat_chained = '0;
    chained_vld = 1'b0; output_rdy = 1'b0;

    // 1: reset state, then ready as soon as reset releases
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("rst_vld", output_vld, 0);
      chk("rst_crdy", chained_rdy, 0);
      chk("rst_done", done, 0);
    end
    rst_n = 1'b0; #1;
    chk("post_rst_crdy", chained_rdy, 1);
    $display("txn reset: released");

    // 2: full-rate send of W1
    output_dat_chained = W1; chained_vld = 1'b1; output_rdy = 1'b1;
    tick(); chained_vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("t2_vld", output_vld, 1);
      chk("t2_dat", output_dat, k);
      chk("t2_done_early", done, 0);
      chk("t2_crdy_send", chained_rdy, 0);
      $display("txn t2: lane %0d dat=%0h", k, output_dat);
      tick();
    end
    #1;
    chk("t2_done", done, 1);
    chk("t2_vld_idle", output_vld, 0);
    tick(); #1;
    chk("t2_done_pulse", done, 0);

    // 3: output_rdy toggling; each lane held while stalled
    output_dat_chained = W1; chained_vld = 1'b1;
    tick(); chained_vld = 1'b0;
    e = 1;
    for (int c = 0; c < 20 && e < 5; c++) begin
      output_rdy = (c % 2 == 0);
      #1;
      chk("t3_vld", output_vld, 1);
      chk("t3_dat", output_dat, e);
      chk("t3_done_early", done, 0);
      $display("txn t3: cyc %0d rdy=%0b dat=%0h", c, output_rdy, output_dat);
      if (output_rdy) e++;
      tick();
    end
    chk("t3_all_lanes", e, 5);
    #1;
    chk("t3_done", done, 1);
    output_rdy = 1'b1;
    tick();

    // 4: pause after lane 2; new word during SEND is not taken
    output_dat_chained = W1; chained_vld = 1'b1;
    tick(); chained_vld = 1'b0;
    #1; chk("t4_lane1", output_dat, 1);
    tick(); #1; chk("t4_lane2", output_dat, 2);
    tick();
    en_output = 1'b0; output_dat_chained = W2; chained_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_paused_vld", output_vld, 0);
      chk("t4_paused_crdy", chained_rdy, 0);
      $display("txn t4: paused cycle %0d", i);
      tick();
    end
    en_output = 1'b1; #1;
    chk("t4_resume_vld", output_vld, 1);
    chk("t4_lane3", output_dat, 3);
    chk("t4_send_crdy", chained_rdy, 0);
    tick(); #1;
    chk("t4_lane4", output_dat, 4);
    chained_vld = 1'b0;
    tick(); #1;
    chk("t4_done", done, 1);
    tick();

    // 5: reset mid-SEND, then a fresh word
    output_dat_chained = W1; chained_vld = 1'b1;
    tick(); chained_vld = 1'b0;
    #1; chk("t5_lane1", output_dat, 1);
    tick();
    rst_n = 1'b1; #1;
    chk("t5_rst_vld", output_vld, 0);
    chk("t5_rst_crdy", chained_rdy, 0);
    tick();
    rst_n = 1'b0; #1;
    chk("t5_no_done", done, 0);
    chk("t5_idle_vld", output_vld, 0);
    chk("t5_idle_crdy", chained_rdy, 1);
    output_dat_chained = W3; chained_vld = 1'b1;
    tick(); chained_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_vld", output_vld, 1);
      chk("t5_dat", output_dat, exp5[k]);
      $display("txn t5: lane %0d dat=%0h", k, output_dat);
      tick();
    end
    #1; chk("t5_done", done, 1);
    tick();

    // 6: two words presented back to back
`ifdef UNCHAIN_BACK_TO_BACK_EN
    span = 8;
`else
    span = 9;
`endif
    n = 0; dn = 0; first = 0; last = 0; qi = 0;
    for (int c = 0; c < 14; c++) begin
      if (qi < 2) begin
        output_dat_chained = words[qi]; chained_vld = 1'b1;
      end else begin
        chained_vld = 1'b0;
      end
      #1;
      in_f  = chained_vld && chained_rdy;
      out_f = output_vld && output_rdy;
      if (done) dn++;
      if (out_f) begin
        if (n < 8) chk("t6_dat", output_dat, exp6[n]);
        if (n == 0) first = c;
        last = c;
        n++;
        $display("txn t6: cyc %0d dat=%0h", c, output_dat);
      end
      tick();
      if (in_f) qi++;
    end
    chk("t6_lane_count", n, 8);
    chk("t6_span", last - first + 1, span);
    chk("t6_done_count", dn, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
